adc_result_fifo: RTL and testbench

Result buffer directly downstream of the SAR-ADC digital core. Captures each 16-bit conversion result on the core's one-cycle conversion-finished strobe, stores it in a small synchronous FIFO, and presents it to a bus-side reader through a read-enable / data-valid handshake. It decouples the ADC conversion rate from host readout and reports fill level, full/empty and sticky overflow.

---
 rtl/adc_result_fifo.sv | 130 +++++++++++++
 tb/tb_adc_result_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_result_fifo.sv
// Result FIFO behind the SAR-ADC core: strobe-captured writes, rd_en/data_valid readout.
// Define ADC_FIFO_WATERMARK_EN to generate the level-watermark interrupt on irq_out.
module adc_result_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result_in,
    input  logic             result_valid_in,
    input  logic             rd_en_in,
    input  logic             clear_in,
    input  logic [LVL_W-1:0] watermark_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid_out,
    output logic [LVL_W-1:0] level_out,
    output logic             empty_out,
    output logic             full_out,
    output logic             overflow_out,
    output logic             irq_out
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dvalid_q, dvalid_d;
    logic             irq_q, irq_d;

    logic rd_acc_c;
    logic wr_acc_c;

    // Acceptance uses the pre-edge empty/full state; a read frees a slot for a same-cycle write.
    assign rd_acc_c = rd_en_in && !empty_q;
    assign wr_acc_c = result_valid_in && (!full_q || rd_acc_c);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        data_d   = data_q;
        dvalid_d = 1'b0;
        irq_d    = 1'b0;

        if (clear_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else if (result_valid_in) begin
                ovf_d = 1'b1;
            end
            if (rd_acc_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                data_d   = mem_q[rd_ptr_q];
                dvalid_d = 1'b1;
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_W'(DEPTH));

`ifdef ADC_FIFO_WATERMARK_EN
        // Next-state level so irq_out moves on the same edge as level_out.
        irq_d = (watermark_in != '0) && (level_d >= watermark_in);
`endif
    end

`ifndef ADC_FIFO_WATERMARK_EN
    logic unused_watermark;
    assign unused_watermark = ^watermark_in;
`endif

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            dvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            irq_q    <= irq_d;
        end
    end

    // Storage array is not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c && !clear_in) begin
            mem_q[wr_ptr_q] <= result_in;
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = dvalid_q;
    assign level_out      = level_q;
    assign empty_out      = empty_q;
    assign full_out       = full_q;
    assign overflow_out   = ovf_q;
    assign irq_out        = irq_q;

endmodule

// File: tb/tb_adc_result_fifo.sv
// Self-checking bench for adc_result_fifo: queue reference model plus a popped-data scoreboard.
module tb_adc_result_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned LVL_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] result_in;
    logic             result_valid_in;
    logic             rd_en_in;
    logic             clear_in;
    logic [LVL_W-1:0] watermark_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid_out;
    logic [LVL_W-1:0] level_out;
    logic             empty_out;
    logic             full_out;
    logic             overflow_out;
    logic             irq_out;

    always #5 clk = ~clk;

    adc_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LVL_W(LVL_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .result_in       (result_in),
        .result_valid_in (result_valid_in),
        .rd_en_in        (rd_en_in),
        .clear_in        (clear_in),
        .watermark_in    (watermark_in),
        .data_out        (data_out),
        .data_valid_out  (data_valid_out),
        .level_out       (level_out),
        .empty_out       (empty_out),
        .full_out        (full_out),
        .overflow_out    (overflow_out),
        .irq_out         (irq_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a plain queue, plus sticky overflow and last popped word.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf = 1'b0;
    logic [WIDTH-1:0] m_last = '0;
    logic             m_valid = 1'b0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned exp_irq();
        int unsigned lvl = 32'(mq.size());
        int unsigned wm  = 32'(watermark_in);
`ifdef ADC_FIFO_WATERMARK_EN
        return (wm != 0 && lvl >= wm) ? 1 : 0;
`else
        if (wm > lvl) return 0;
        return 0;
`endif
    endfunction

    task automatic check_state();
        chk("level", 32'(level_out), 32'(mq.size()));
        chk("empty", 32'(empty_out), (mq.size() == 0) ? 1 : 0);
        chk("full", 32'(full_out), (mq.size() == DEPTH) ? 1 : 0);
        chk("overflow", 32'(overflow_out), 32'(m_ovf));
        chk("irq", 32'(irq_out), exp_irq());
        chk("data_valid", 32'(data_valid_out), 32'(m_valid));
        chk("data_hold", 32'(data_out), 32'(m_last));
    endtask

    // One clock of stimulus; the model advances from the pre-edge state.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic rd, input logic clr);
        bit rd_acc;
        bit wr_acc;
        result_valid_in = v;
        result_in       = d;
        rd_en_in        = rd;
        clear_in        = clr;
        rd_acc  = rd && (mq.size() > 0);
        wr_acc  = v && ((mq.size() < DEPTH) || rd_acc);
        m_valid = 1'b0;
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (rd_acc) begin
                m_last = mq.pop_front();
                exp_q.push_back(m_last);
                m_valid = 1'b1;
            end
            if (wr_acc) mq.push_back(d);
            else if (v) m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        result_valid_in = 1'b0;
        rd_en_in        = 1'b0;
        clear_in        = 1'b0;
        check_state();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        mq.delete();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_last  = '0;
        m_valid = 1'b0;
        check_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every data_valid_out pulse must match the next expected pop.
    always @(negedge clk) begin
        if (!rst && data_valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no pop", data_out);
            end else begin
                chk("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst             = 1'b1;
        result_in       = '0;
        result_valid_in = 1'b0;
        rd_en_in        = 1'b0;
        clear_in        = 1'b0;
        watermark_in    = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Ordering
        for (int i = 1; i <= 5; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Overflow: ninth write dropped, sticky until clear
        for (int i = 0; i < 9; i++) cycle(1'b1, WIDTH'(16'h0A00 + i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Full with simultaneous read and write
        for (int i = 0; i < 8; i++) cycle(1'b1, WIDTH'(16'h0C00 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'h0BEE, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Wrap and empty read; also write+read on empty (no fall-through)
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, WIDTH'(16'h0100 + i), 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 16'h0777, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Watermark
        watermark_in = LVL_W'(3);
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(16'h0D00 + i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 16'h0D10, 1'b0, 1'b0);
        cycle(1'b1, 16'h0D11, 1'b1, 1'b1);

        // Reset mid-traffic; a later pop must find nothing
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(16'h0E00 + i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) watermark_in = LVL_W'($urandom_range(0, DEPTH));
            cycle(1'($urandom_range(0, 99) < 55), WIDTH'($urandom),
                  1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 63) == 0));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
